// File: rtl/ref_sweep_ctrl_pkg.sv
// caf_ref_pkg: shared sequencer state encoding and reference buffer timing.
package caf_ref_pkg;
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    localparam int BUF_READ_LATENCY = 2;
endpackage

// File: rtl/ref_sweep_ctrl_if.sv
// ref_sweep_ctrl_if: reference buffer read port plus correlator sample stream.
// REF_SWEEP_PASS_TAG_EN adds out_pass to the stream.
interface ref_sweep_ctrl_if #(
    parameter int index_bits = 4,
    parameter int i_bits = 12,
`ifdef REF_SWEEP_PASS_TAG_EN
    parameter int pass_bits = 8,
`endif
    parameter int q_bits = 12
);
    logic [index_bits-1:0] buf_raddr;
    logic buf_rvalid, buf_rready, buf_dvalid;
    logic [i_bits-1:0] buf_i, out_i;
    logic [q_bits-1:0] buf_q, out_q;
    logic out_valid, out_ready, out_last;
`ifdef REF_SWEEP_PASS_TAG_EN
    logic [pass_bits-1:0] out_pass;
`endif
    modport master (
        output buf_raddr, buf_rvalid, buf_rready, out_i, out_q, out_valid, out_last,
`ifdef REF_SWEEP_PASS_TAG_EN
        out_pass,
`endif
        input buf_i, buf_q, buf_dvalid, out_ready
    );
    modport slave (
        input buf_raddr, buf_rvalid, buf_rready, out_i, out_q, out_valid, out_last,
`ifdef REF_SWEEP_PASS_TAG_EN
        out_pass,
`endif
        output buf_i, buf_q, buf_dvalid, out_ready
    );
endinterface

// File: rtl/ref_skid_fifo.sv
// ref_skid_fifo: synchronous FIFO with occupancy count; push and pop may coincide at any fill level.
module ref_skid_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic full,
    output logic empty,
    output logic [$clog2(depth+1)-1:0] count
);
    localparam int aw = depth > 1 ? $clog2(depth) : 1;
    localparam int cw = $clog2(depth + 1);
    logic [width-1:0] mem [depth];
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full = count == cw'(depth);
    assign empty = count == '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == aw'(depth - 1) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == aw'(depth - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + cw'(do_push) - cw'(do_pop);
        end
endmodule

// File: rtl/ref_sweep_ctrl.sv
// ref_sweep_ctrl: credit-metered multi-pass sweeper of the CAF reference buffer feeding the correlator.
// Define REF_SWEEP_PASS_TAG_EN to tag every output sample with its pass index (out_pass).
module ref_sweep_ctrl #(
    parameter int buffer_length = 10,
    parameter int index_bits = 4,
    parameter int i_bits = 12,
    parameter int q_bits = 12,
    parameter int pass_bits = 8,
    parameter int fifo_depth = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [pass_bits-1:0] num_passes,
    output logic busy,
    output logic done,
    ref_sweep_ctrl_if.master bus
);
    import caf_ref_pkg::*;
    localparam int lat = BUF_READ_LATENCY;
    localparam int cw = $clog2(fifo_depth + 1);
`ifdef REF_SWEEP_PASS_TAG_EN
    localparam int ew = i_bits + q_bits + 1 + pass_bits;
`else
    localparam int ew = i_bits + q_bits + 1;
`endif
    state_t state;
    logic [index_bits-1:0] addr;
    logic [pass_bits-1:0] pass, last_pass;
    logic [cw-1:0] credits, count;
    logic [lat-1:0] dl_v, dl_last, dl_v_next;
    logic issue, push, pop, full, empty, at_end;
    logic [ew-1:0] din, dout;
    assign at_end = addr == index_bits'(buffer_length - 1);
    // credits bound in-flight reads plus FIFO occupancy, so !full never actually gates
    assign issue = state == SWEEP && credits != '0 && !full;
    assign push = bus.buf_dvalid && state != IDLE;
    assign pop = bus.out_ready && !empty;
    assign dl_v_next = (dl_v << 1) | lat'(issue);
    assign busy = state == SWEEP || state == DRAIN;
    assign done = state == DONE;
    assign bus.buf_raddr = addr;
    assign bus.buf_rvalid = issue;
    assign bus.buf_rready = busy;
    assign bus.out_valid = !empty;
    assign bus.out_i = empty ? '0 : dout[ew-1 -: i_bits];
    assign bus.out_q = empty ? '0 : dout[ew-i_bits-1 -: q_bits];
    assign bus.out_last = !empty && dout[ew-i_bits-q_bits-1];
`ifdef REF_SWEEP_PASS_TAG_EN
    logic [pass_bits-1:0] dl_pass [lat];
    assign din = {bus.buf_i, bus.buf_q, dl_last[lat-1], dl_pass[lat-1]};
    assign bus.out_pass = empty ? '0 : dout[pass_bits-1:0];
    always_ff @(posedge clk or posedge reset)
        if (reset) for (int k = 0; k < lat; k++) dl_pass[k] <= '0;
        else begin
            dl_pass[0] <= pass;
            for (int k = 1; k < lat; k++) dl_pass[k] <= dl_pass[k-1];
        end
`else
    assign din = {bus.buf_i, bus.buf_q, dl_last[lat-1]};
`endif
    ref_skid_fifo #(.width(ew), .depth(fifo_depth)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .dout(dout), .full(full), .empty(empty), .count(count)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            addr <= '0;
            pass <= '0;
            last_pass <= '0;
            credits <= cw'(fifo_depth);
            dl_v <= '0;
            dl_last <= '0;
        end else begin
            credits <= credits - cw'(issue) + cw'(pop);
            dl_v <= dl_v_next;
            dl_last <= (dl_last << 1) | lat'(issue && at_end);
            case (state)
                IDLE: if (start) begin
                    last_pass <= num_passes == '0 ? '0 : num_passes - 1'b1;
                    addr <= '0;
                    pass <= '0;
                    state <= SWEEP;
                end
                SWEEP: if (issue) begin
                    addr <= at_end ? '0 : addr + 1'b1;
                    if (at_end) pass <= pass + 1'b1;
                    if (at_end && pass == last_pass) state <= DRAIN;
                end
                // leave on the accept that empties the FIFO with nothing left in flight
                DRAIN: if (dl_v_next == '0 && !push && count == cw'(pop)) state <= DONE;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_ref_sweep_ctrl.sv
// tb_ref_sweep_ctrl: directed checks of ref_sweep_ctrl against a 2-cycle buffer holding value k at address k.
module tb_ref_sweep_ctrl;
    logic clk = 0, reset = 1, start = 0;
    logic [7:0] num_passes = 0;
    logic busy, done;
    ref_sweep_ctrl_if bus ();
    ref_sweep_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .num_passes(num_passes),
        .busy(busy), .done(done), .bus(bus)
    );
    always #5 clk = ~clk;

    logic [1:0] p_v = 0;
    logic [3:0] p_a [2];
    always @(posedge clk) begin
        p_v <= {p_v[0], bus.buf_rvalid};
        p_a[0] <= bus.buf_raddr;
        p_a[1] <= p_a[0];
    end
    assign bus.buf_dvalid = p_v[1];
    assign bus.buf_i = 12'(p_a[1]);
    assign bus.buf_q = 12'(p_a[1]) + 12'd50;

    int nchk = 0, nerr = 0;
    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;
    int q_s[$];
    int q_p[$];
    bit running = 0, got_done = 0;
    int done_cnt = 0, done_cyc = 0, acc_cyc = 0, busy_gap = 0, issued = 0, popped = 0, max_out = 0;
    always @(negedge clk)
        if (!reset) begin
            if (bus.buf_rvalid) issued++;
            if (bus.out_valid && bus.out_ready) begin
                q_s.push_back({bus.out_i, bus.out_q, bus.out_last});
`ifdef REF_SWEEP_PASS_TAG_EN
                q_p.push_back(int'(bus.out_pass));
`endif
                popped++;
                acc_cyc = cyc;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                got_done = 1;
                running = 0;
            end else if (running && !busy) busy_gap++;
        end

    task automatic check_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " buf_rvalid"}, bus.buf_rvalid, 0);
        chk({tag, " buf_rready"}, bus.buf_rready, 0);
        chk({tag, " buf_raddr"}, bus.buf_raddr, 0);
        chk({tag, " out_valid"}, bus.out_valid, 0);
        chk({tag, " out_last"}, bus.out_last, 0);
        chk({tag, " out_i"}, bus.out_i, 0);
        chk({tag, " out_q"}, bus.out_q, 0);
`ifdef REF_SWEEP_PASS_TAG_EN
        chk({tag, " out_pass"}, bus.out_pass, 0);
`endif
    endtask

    // mode 0: ready always, 1: random ready, 2: 20-cycle stall, 3: extra start while busy
    task automatic run(input int np, input int mode, input string tag);
        int n_exp, k;
        q_s.delete();
        q_p.delete();
        done_cnt = 0; got_done = 0; busy_gap = 0; issued = 0; popped = 0; max_out = 0;
        n_exp = (np == 0 ? 1 : np) * 10;
        @(posedge clk); #1;
        num_passes = 8'(np);
        start = 1;
        bus.out_ready = 1;
        @(posedge clk); #1;
        start = 0;
        running = 1;
        for (int c = 0; c < 600 && !got_done; c++) begin
            if (mode == 3 && c == 3) begin
                start = 1;
                num_passes = 5;
            end else start = 0;
            bus.out_ready = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? (c < 5 || c >= 25) : 1'b1;
            if (mode == 2 && c == 24) begin
                chk({tag, " stalled rvalid"}, bus.buf_rvalid, 0);
                chk({tag, " stalled outstanding"}, issued - popped, 4);
                chk({tag, " stalled out_valid"}, bus.out_valid, 1);
            end
            @(posedge clk); #1;
        end
        start = 0;
        chk({tag, " finished"}, got_done, 1);
        chk({tag, " count"}, q_s.size(), n_exp);
        for (int i = 0; i < q_s.size() && i < n_exp; i++) begin
            k = i % 10;
            chk($sformatf("%s sample%0d", tag, i), q_s[i], (k << 13) | ((50 + k) << 1) | (k == 9 ? 1 : 0));
`ifdef REF_SWEEP_PASS_TAG_EN
            chk($sformatf("%s pass%0d", tag, i), q_p[i], i / 10);
`endif
        end
        chk({tag, " done gap"}, done_cyc - acc_cyc, 1);
        chk({tag, " busy gap"}, busy_gap, 0);
        chk({tag, " fifo bound"}, int'(max_out <= 4), 1);
        repeat (2) @(negedge clk);
        chk({tag, " done pulses"}, done_cnt, 1);
        chk({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        bus.out_ready = 0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset = 0;
        run(1, 0, "basic");
        run(3, 0, "multi");
        run(2, 2, "backpressure");
        run(0, 1, "random");
        run(1, 3, "start busy");
        @(posedge clk); #1;
        num_passes = 1;
        start = 1;
        bus.out_ready = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(posedge clk);
        #1 reset = 1;
        #1 check_zero("midreset");
        @(posedge clk); #1;
        reset = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("late return out_valid", bus.out_valid, 0);
        chk("late return busy", busy, 0);
        run(1, 0, "after reset");
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
